// File: rtl/cache_read_only.sv
// Direct-mapped read-only byte cache over an internal 2048x8 backing ROM.
// Misses refill a whole 4-byte line over four beats, then the read is served as a hit.
module cache_read_only #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned OFFSET_W = 2,
   parameter int unsigned INDEX_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] dout,
   input  logic [DATA_W-1:0] din
);

   localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int unsigned LINES = 1 << INDEX_W;
   localparam int unsigned WORDS = 1 << OFFSET_W;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {
      COMPARE = 1'b0,
      FILL    = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DATA_W-1:0]   mem        [DEPTH];
   logic [TAG_W-1:0]    tag_array  [LINES];
   logic [DATA_W-1:0]   data_array [LINES][WORDS];
   logic [LINES-1:0]    valid;

   logic [OFFSET_W-1:0] offset;
   logic [INDEX_W-1:0]  index;
   logic [TAG_W-1:0]    tag;

   logic [OFFSET_W-1:0] cnt;
   logic [INDEX_W-1:0]  fill_index;
   logic [TAG_W-1:0]    fill_tag;
   logic [ADDR_W-1:0]   fill_addr;
   logic [DATA_W-1:0]   mem_rd;

   logic hit_c;
   logic miss_c;
   logic fill_we_c;
   logic fill_done_c;
   logic dout_we_c;

   // The write-data port is reserved and intentionally has no effect.
   logic unused_din;
   assign unused_din = ^din;

   // Backing memory: constant contents, mem[a] = low byte of a.
   for (genvar g = 0; g < DEPTH; g++) begin : g_mem
      assign mem[g] = DATA_W'(g);
   end

   assign offset    = address[OFFSET_W-1:0];
   assign index     = address[OFFSET_W +: INDEX_W];
   assign tag       = address[ADDR_W-1 -: TAG_W];

   assign hit_c     = valid[index] && (tag_array[index] == tag);
   assign fill_addr = {fill_tag, fill_index, cnt};
   assign mem_rd    = mem[fill_addr];

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= COMPARE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         COMPARE: if (!hit_c) state_nxt = FILL;
         FILL:    if (cnt == OFFSET_W'(WORDS - 1)) state_nxt = COMPARE;
         default: state_nxt = COMPARE;
      endcase
   end

   // Control outputs decoded from the current state.
   always_comb begin
      miss_c      = 1'b0;
      fill_we_c   = 1'b0;
      fill_done_c = 1'b0;
      dout_we_c   = 1'b0;
      case (state)
         COMPARE: begin
            dout_we_c = hit_c;
            miss_c    = !hit_c;
         end
         FILL: begin
            fill_we_c   = 1'b1;
            fill_done_c = (cnt == OFFSET_W'(WORDS - 1));
         end
         default: ;
      endcase
   end

   // Fill bookkeeping, valid bits and registered read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         fill_index <= '0;
         fill_tag   <= '0;
         valid      <= '0;
         dout       <= '0;
      end else begin
         if (miss_c) begin
            cnt        <= '0;
            fill_index <= index;
            fill_tag   <= tag;
         end else if (fill_we_c) begin
            cnt <= cnt + OFFSET_W'(1);
         end
         if (fill_done_c) begin
            valid[fill_index] <= 1'b1;
         end
         if (dout_we_c) begin
            dout <= data_array[index][offset];
         end
      end
   end

   // Tag and data storage need no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (fill_we_c) begin
         data_array[fill_index][cnt] <= mem_rd;
      end
      if (fill_done_c) begin
         tag_array[fill_index] <= fill_tag;
      end
   end

endmodule

// File: tb/tb_cache_read_only.sv
// Scoreboard bench for cache_read_only: a reference tag/valid model predicts
// hit/miss latency and the expected byte for every read.
module tb_cache_read_only;

   logic        clk;
   logic        reset;
   logic [10:0] address;
   logic [7:0]  dout;
   logic [7:0]  din;

   typedef struct {
      logic [10:0] addr;
      logic [7:0]  data;
   } sb_item_t;

   sb_item_t    sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          valid_m [8];
   logic [5:0]  tag_m   [8];
   logic [7:0]  last_dout;

   cache_read_only dut (
      .clk     (clk),
      .reset   (reset),
      .address (address),
      .dout    (dout),
      .din     (din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s addr=%h got=%h exp=%h", tag, address, got, exp);
      end
   endtask

   // Call at a negedge; returns at the negedge after the expected result edge.
   task automatic do_read(input logic [10:0] a);
      logic [2:0] idx;
      logic [5:0] tg;
      bit         hit;
      int         lat;
      sb_item_t   it;
      idx = a[4:2];
      tg  = a[10:5];
      hit = valid_m[idx] && (tag_m[idx] == tg);
      lat = hit ? 1 : 6;
      sb.push_back('{addr: a, data: a[7:0]});
      address = a;
      for (int e = 1; e <= lat; e++) begin
         din = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         if (e < lat) check(hit ? "hit_hold" : "fill_hold", dout, last_dout);
      end
      if (sb.size() == 0) begin
         check("sb_empty", 8'hxx, 8'h00);
      end else begin
         it = sb.pop_front();
         check(hit ? "hit_data" : "miss_data", dout, it.data);
         last_dout = it.data;
      end
      if (!hit) begin
         valid_m[idx] = 1'b1;
         tag_m[idx]   = tg;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [10:0] a;
      reset   = 1'b0;
      address = 11'h000;
      din     = 8'h00;
      last_dout = 8'h00;
      for (int i = 0; i < 8; i++) begin
         valid_m[i] = 1'b0;
         tag_m[i]   = '0;
      end

      for (int i = 0; i < 2; i++) begin
         din = 8'($urandom);
         @(negedge clk);
         check("reset_dout", dout, 8'h00);
      end
      reset = 1'b1;

      do_read(11'h000);
      do_read(11'h005);
      do_read(11'h006);
      do_read(11'h007);
      do_read(11'h004);
      do_read(11'h021);
      do_read(11'h405);
      do_read(11'h006);

      // Abort a fill of 0x0A0 during its third beat.
      address = 11'h0A0;
      for (int e = 1; e <= 3; e++) begin
         din = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("abort_hold", dout, last_dout);
      end
      reset = 1'b0;
      #1;
      check("abort_dout", dout, 8'h00);
      for (int i = 0; i < 8; i++) valid_m[i] = 1'b0;
      last_dout = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check("abort_reset_hold", dout, 8'h00);
      reset = 1'b1;
      do_read(11'h0A0);
      do_read(11'h0A3);

      // Random reads over a small footprint so both hits and evictions occur.
      for (int i = 0; i < 40; i++) begin
         a = 11'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) a = a | 11'h400;
         do_read(a);
      end

      if (sb.size() != 0) check("sb_leftover", 8'(sb.size()), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_read_only.md
Name: cache_read_only

Overview:
Direct-mapped, read-only byte cache in front of an internal 2048x8 backing memory, addressed by an 11-bit byte address.
- Every cycle it compares the address against its tag and valid arrays.
- On a hit it returns the cached byte.
- On a miss an FSM with a beat counter refills the whole line from backing memory, then serves the hit.
- Used as a standalone cache demonstrator; the top level contains the backing RAM, tag RAM, data RAM, valid bits, comparator, counter, mux and FSM.

Parameters:
ADDR_W, 11, byte address width (backing memory depth = 2^ADDR_W).
DATA_W, 8, data byte width.
OFFSET_W, 2, byte-offset bits per line (4-byte lines).
INDEX_W, 3, index bits (8 lines); tag width = ADDR_W-INDEX_W-OFFSET_W = 6.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
address  input  ADDR_W  byte read address, sampled every cycle.
dout  output  DATA_W  registered read data.
din  input  DATA_W  reserved write-data port; ignored, must never affect dout or state.

Behaviour:
- Address split: offset = address[1:0], index = address[4:2], tag = address[10:5].
- Backing memory:
  - Asynchronous read, never written.
  - Initialised so that mem[a] = a[7:0], i.e. the low 8 bits of the address.
- Reset (reset==0, asynchronous):
  - All 8 valid bits cleared; FSM goes to COMPARE; beat counter = 0; dout = 0.
  - Tag and data arrays need not be cleared.
  - Reset asserted mid-fill aborts the fill; the partially filled line stays invalid.
- FSM states: COMPARE, FILL.
- COMPARE:
  - hit = valid[index] && tag_array[index]==tag.
  - Hit: dout <= data[index][offset] at the next edge (1-cycle latency); stay in COMPARE.
  - Miss: latch index and tag of the current address, clear counter, go to FILL; dout holds its previous value.
- FILL:
  - Each cycle writes data[latched_index][counter] <= mem[{latched_tag, latched_index, counter}], then counter increments.
  - After beat 3 (counter wraps 3 -> 0), write tag_array[latched_index] = latched_tag, set valid[latched_index], return to COMPARE.
  - Address changes during FILL are ignored; the fill always completes for the latched line.
  - dout holds during FILL.
- Miss latency: after the address is presented, the sequence is miss-detect edge, 4 fill edges, then the hit edge. dout shows the new byte 6 rising edges after the address is stable.
- If the address changes while in COMPARE, it is re-evaluated the same cycle; there is no request/valid handshake.
- Conflict: a different tag at an occupied index evicts the old line (overwrite, no writeback).
- No hit/busy outputs; the design is read-only, with no write path.

Test Plan:
- Reset low for 2 cycles, address=0 -> dout=0 throughout reset, all lines invalid; after release, address 0 misses and dout=0 (mem[0]) after 6 edges.
- address=0x005 after reset -> miss fills line index 1 with tag 0, dout=5 on the 6th edge; dout holds its previous value during the fill.
- Then address=0x006, 0x007, 0x004 -> hits, dout=6, 7, 4 each one edge after the address changes.
- address=0x021 -> index 0, tag 1, miss, dout=33 after 6 edges.
- address=0x405 (index 1, tag 32) -> evicts the 0x005 line, dout=5. Re-reading 0x006 then misses again and returns 6 after 6 edges.
- Mid-fill abort: start a miss on 0x0A0, assert reset during beat 2 -> dout=0 and FSM in COMPARE. After release, 0x0A0 misses again (line invalid) and returns 0xA0. Toggling din to arbitrary values never changes dout.
